// File: rtl/nkmm_prog_mem.sv
// Program memory with a registered CPU fetch port and a byte-serial loader.
// While a load is running the fetch port returns FILL and is marked not valid.
module nkmm_prog_mem #(
  parameter int                    INSN_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1024,
  parameter logic [INSN_WIDTH-1:0] FILL       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  output logic [INSN_WIDTH-1:0] prog_data_o,
  output logic                  prog_valid_o,
  input  logic                  ld_start_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_valid_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  busy_o,
  output logic                  ld_err_o,
  output logic [1:0]            dbg_state
);

  localparam int NBYTES = INSN_WIDTH / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int MIW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WPTR_MAX  = '1;
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [BCW-1:0]        bcnt;
  logic [INSN_WIDTH-1:0] asm_q;
  logic [INSN_WIDTH-1:0] word_nx;
  logic                  byte_acc;
  logic                  word_done;
  logic                  wptr_ok;
  logic                  mem_we;
  logic                  fetch_ok;

  // Loader handshake: a byte transfers on a rising edge where ld_valid_i and
  // ld_ready_o are both 1; ld_ready_o depends only on state, never on ld_valid_i.
  assign ld_ready_o = (state == LOAD);
  assign busy_o     = (state != IDLE);
  assign dbg_state  = state;

  assign byte_acc  = ld_valid_i & ld_ready_o;
  assign word_nx   = asm_q | (INSN_WIDTH'(ld_data_i) << {bcnt, 3'b000});
  assign word_done = byte_acc & (ld_last_i | (bcnt == LAST_BYTE));
  assign wptr_ok   = ({1'b0, wptr} < DEPTH_L);
  assign mem_we    = word_done & wptr_ok;
  assign fetch_ok  = ({1'b0, prog_addr_i} < DEPTH_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ld_start_i) state_nx = LOAD;
      LOAD:    if (byte_acc && ld_last_i) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Assembly register only ever holds bytes of the current word, so a short
  // final word is zero-filled in its upper bytes for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      bcnt     <= '0;
      asm_q    <= '0;
      ld_err_o <= 1'b0;
    end else if (state == IDLE && ld_start_i) begin
      wptr     <= ld_addr_i;
      bcnt     <= '0;
      asm_q    <= '0;
      ld_err_o <= 1'b0;
    end else if (byte_acc) begin
      if (word_done) begin
        asm_q <= '0;
        bcnt  <= '0;
        if (wptr != WPTR_MAX) wptr <= wptr + 1'b1;
        if (!wptr_ok) ld_err_o <= 1'b1;
      end else begin
        asm_q <= word_nx;
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

  // Storage is never reset so program contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr[MIW-1:0]] <= word_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_data_o  <= FILL;
      prog_valid_o <= 1'b0;
    end else begin
      prog_valid_o <= (state == IDLE);
      if (state == IDLE && fetch_ok) prog_data_o <= mem[prog_addr_i[MIW-1:0]];
      else                           prog_data_o <= FILL;
    end
  end

endmodule
